crc4_frame_checker: RTL and testbench

Receive-side counterpart of the team's serial CRC-4 generator. Deserialises a framed bit stream (payload of PAYLOAD_BITS followed by a 4-bit CRC), recomputes CRC-4 over the payload with the identical LFSR, and compares it against the received CRC. Sits at the serial link input, ahead of payload consumers, and flags good/bad frames.

---
 rtl/crc4_pkg.sv | 22 ++
 rtl/crc4_lfsr.sv | 27 ++
 rtl/crc4_frame_checker.sv | 154 +++++++++++++++
 tb/tb_crc4_frame_checker.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/crc4_pkg.sv
// Shared CRC-4 definitions for the serial CRC-4 generator/checker pair.
//   CRC_W        : CRC width (4)
//   crc4_state_e : frame checker FSM states
//   crc4_next()  : one LFSR step for a single payload bit
package crc4_pkg;

  localparam int CRC_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_CRC
  } crc4_state_e;

  // fb = b ^ s[0]; s3' = fb; s2' = fb ^ s3; s1' = s2; s0' = s1
  function automatic logic [CRC_W-1:0] crc4_next(input logic [CRC_W-1:0] s, input logic b);
    logic fb;
    fb = b ^ s[0];
    return {fb, fb ^ s[3], s[2], s[1]};
  endfunction

endpackage

// File: rtl/crc4_lfsr.sv
// Serial CRC-4 LFSR.
//   clk    : rising-edge clock
//   rst    : asynchronous reset, active-low
//   en     : advance the LFSR by one bit
//   clr    : with en, restart from zero before applying bit_in
//   bit_in : payload bit
//   state  : current LFSR contents
module crc4_lfsr
  import crc4_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             bit_in,
  output logic [CRC_W-1:0] state
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= '0;
    end else if (en) begin
      state <= crc4_next(clr ? '0 : state, bit_in);
    end
  end

endmodule

// File: rtl/crc4_frame_checker.sv
// Receive-side CRC-4 frame checker.
// Deserialises PAYLOAD_BITS payload bits (first bit -> data_out[0]) followed
// by a 4-bit CRC (first bit -> rx_crc[0]), recomputes the CRC over the
// payload and flags the frame good or bad.
//   clk, rst    : clock, asynchronous active-low reset
//   s_in, en    : serial bit and its valid strobe (en=0 stalls everything)
//   sof         : start of frame, qualified by en
//   data_out    : payload of the last completed frame
//   rx_crc      : CRC received in the last completed frame
//   calc_crc    : CRC computed over the last completed payload
//   frame_done  : one-cycle completion pulse
//   crc_ok/err  : one-cycle verdict pulses alongside frame_done
//   frame_abort : one-cycle pulse when sof drops an in-progress frame
//   busy        : frame in progress
module crc4_frame_checker
  import crc4_pkg::*;
#(
  parameter int PAYLOAD_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_in,
  input  logic                    en,
  input  logic                    sof,
  output logic [PAYLOAD_BITS-1:0] data_out,
  output logic [CRC_W-1:0]        rx_crc,
  output logic [CRC_W-1:0]        calc_crc,
  output logic                    frame_done,
  output logic                    crc_ok,
  output logic                    crc_err,
  output logic                    frame_abort,
  output logic                    busy
);

  localparam int CNT_W = $clog2(PAYLOAD_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAYLOAD_BITS - 1);

  crc4_state_e             state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [1:0]              crc_idx, crc_idx_nxt;
  logic [PAYLOAD_BITS-1:0] pay_sh, pay_nxt;
  logic [CRC_W-1:0]        rx_sh, rx_nxt;
  logic [CRC_W-1:0]        lfsr_state;
  logic                    lfsr_en, lfsr_clr;
  logic                    complete, abort, crc_match;

  // The LFSR only advances on payload bits, so during the CRC phase it
  // already holds the computed CRC; no separate compare register is needed.
  crc4_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (lfsr_en),
    .clr   (lfsr_clr),
    .bit_in(s_in),
    .state (lfsr_state)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      crc_idx <= '0;
      pay_sh  <= '0;
      rx_sh   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      crc_idx <= crc_idx_nxt;
      pay_sh  <= pay_nxt;
      rx_sh   <= rx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    crc_idx_nxt = crc_idx;
    pay_nxt     = pay_sh;
    rx_nxt      = rx_sh;
    lfsr_en     = 1'b0;
    lfsr_clr    = 1'b0;
    complete    = 1'b0;
    abort       = 1'b0;
    if (en) begin
      if (sof) begin
        // sof always starts a new frame; if one was in flight it is dropped
        abort       = (state != ST_IDLE);
        lfsr_en     = 1'b1;
        lfsr_clr    = 1'b1;
        pay_nxt     = '0;
        pay_nxt[0]  = s_in;
        rx_nxt      = '0;
        crc_idx_nxt = '0;
        if (PAYLOAD_BITS == 1) begin
          state_nxt = ST_CRC;
          cnt_nxt   = '0;
        end else begin
          state_nxt = ST_PAYLOAD;
          cnt_nxt   = CNT_W'(1);
        end
      end else begin
        case (state)
          ST_PAYLOAD: begin
            lfsr_en = 1'b1;
            for (int unsigned i = 0; i < PAYLOAD_BITS; i++) begin
              if (cnt == CNT_W'(i)) pay_nxt[i] = s_in;
            end
            if (cnt == LAST_IDX) begin
              state_nxt = ST_CRC;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end
          ST_CRC: begin
            rx_nxt[crc_idx] = s_in;
            crc_idx_nxt     = crc_idx + 2'd1;
            if (crc_idx == 2'd3) begin
              state_nxt = ST_IDLE;
              complete  = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign crc_match = (rx_nxt == lfsr_state);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out    <= '0;
      rx_crc      <= '0;
      calc_crc    <= '0;
      frame_done  <= 1'b0;
      crc_ok      <= 1'b0;
      crc_err     <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      frame_done  <= complete;
      crc_ok      <= complete & crc_match;
      crc_err     <= complete & ~crc_match;
      frame_abort <= abort;
      if (complete) begin
        data_out <= pay_sh;
        rx_crc   <= rx_nxt;
        calc_crc <= lfsr_state;
      end
    end
  end

endmodule

// File: tb/tb_crc4_frame_checker.sv
module tb_crc4_frame_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       s_in = 1'b0;
  logic       en = 1'b0;
  logic       sof = 1'b0;
  logic [7:0] data_out;
  logic [3:0] rx_crc;
  logic [3:0] calc_crc;
  logic       frame_done, crc_ok, crc_err, frame_abort, busy;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int n_done, n_ok, n_err, n_abort, n_overlap, n_stall_pulse;
  int last_done_cyc, prev_done_cyc;

  always #5 clk = ~clk;

  crc4_frame_checker #(.PAYLOAD_BITS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_in       (s_in),
    .en         (en),
    .sof        (sof),
    .data_out   (data_out),
    .rx_crc     (rx_crc),
    .calc_crc   (calc_crc),
    .frame_done (frame_done),
    .crc_ok     (crc_ok),
    .crc_err    (crc_err),
    .frame_abort(frame_abort),
    .busy       (busy)
  );

  // Reflected bitwise CRC-4 (poly x^4+x+1 reflected -> 0xC), LSB-first payload.
  function automatic logic [3:0] ref_crc(input logic [7:0] pay);
    int unsigned c, x;
    c = 0;
    for (int i = 0; i < 8; i++) begin
      x = c ^ 32'(pay[i]);
      c = (x >> 1) ^ (((x & 1) != 0) ? 32'd12 : 32'd0);
    end
    return c[3:0];
  endfunction

  // Drive one cycle, then observe outputs 1 time unit after the edge.
  task automatic step(input logic b, input logic e, input logic s);
    s_in = b; en = e; sof = s;
    @(posedge clk);
    #1;
    cyc++;
    if (frame_done) begin
      n_done++;
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
    end
    if (crc_ok) n_ok++;
    if (crc_err) n_err++;
    if (frame_abort) n_abort++;
    if (frame_done && frame_abort) n_overlap++;
    if (!e && (frame_done || crc_ok || crc_err || frame_abort)) n_stall_pulse++;
  endtask

  task automatic clear_counts();
    n_done = 0; n_ok = 0; n_err = 0; n_abort = 0; n_overlap = 0; n_stall_pulse = 0;
  endtask

  task automatic send_frame(input logic [7:0] pay, input logic [3:0] crc, input int stall_pct);
    logic b;
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < 3; k++) begin
        if (int'($urandom_range(99)) < stall_pct)
          step(1'($urandom_range(1)), 1'b0, 1'($urandom_range(1)));
      end
      b = (i < 8) ? pay[i] : crc[i-8];
      step(b, 1'b1, (i == 0));
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    total_cnt++;
    if ({data_out, rx_crc, calc_crc} !== 16'h0) $display("FAIL reset_data: got %h expected 0000", {data_out, rx_crc, calc_crc});
    else pass_cnt++;
    total_cnt++;
    if ({frame_done, crc_ok, crc_err, frame_abort, busy} !== 5'b0) $display("FAIL reset_flags: got %b expected 00000", {frame_done, crc_ok, crc_err, frame_abort, busy});
    else pass_cnt++;
    #2 rst = 1'b1;
    clear_counts();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
    total_cnt++;
    if (busy !== 1'b0 || n_done != 0 || n_abort != 0) $display("FAIL idle_no_sof: busy %b done %0d abort %0d expected 0 0 0", busy, n_done, n_abort);
    else pass_cnt++;
  endtask

  task automatic test_good_frame();
    clear_counts();
    send_frame(8'h01, 4'h7, 0);
    total_cnt++;
    if ({frame_done, crc_ok, crc_err, frame_abort} !== 4'b1100) $display("FAIL good_pulses: got %b expected 1100", {frame_done, crc_ok, crc_err, frame_abort});
    else pass_cnt++;
    total_cnt++;
    if (data_out !== 8'h01 || rx_crc !== 4'h7 || calc_crc !== 4'h7) $display("FAIL good_data: got %h/%h/%h expected 01/7/7", data_out, rx_crc, calc_crc);
    else pass_cnt++;
    step(1'b0, 1'b0, 1'b0);
    total_cnt++;
    if ({frame_done, crc_ok, busy} !== 3'b000 || data_out !== 8'h01) $display("FAIL good_after: flags %b data %h expected 000 01", {frame_done, crc_ok, busy}, data_out);
    else pass_cnt++;
  endtask

  task automatic test_bad_crc();
    clear_counts();
    send_frame(8'h01, 4'h6, 0);
    total_cnt++;
    if ({frame_done, crc_ok, crc_err} !== 3'b101) $display("FAIL bad_pulses: got %b expected 101", {frame_done, crc_ok, crc_err});
    else pass_cnt++;
    total_cnt++;
    if (rx_crc !== 4'h6 || calc_crc !== 4'h7) $display("FAIL bad_crcs: got %h/%h expected 6/7", rx_crc, calc_crc);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    clear_counts();
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, (i == 0));
      step(1'b1, 1'b0, 1'b1);
    end
    total_cnt++;
    if (n_ok != 1 || n_done != 1 || n_err != 0) $display("FAIL stall_ok: ok %0d done %0d err %0d expected 1 1 0", n_ok, n_done, n_err);
    else pass_cnt++;
    total_cnt++;
    if (n_stall_pulse != 0) $display("FAIL stall_pulse: got %0d expected 0", n_stall_pulse);
    else pass_cnt++;
    total_cnt++;
    if (data_out !== 8'h00 || calc_crc !== 4'h0) $display("FAIL stall_data: got %h/%h expected 00/0", data_out, calc_crc);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    clear_counts();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, (i == 0));
    send_frame(8'h01, 4'h7, 0);
    total_cnt++;
    if (n_abort != 1 || n_ok != 1 || n_done != 1 || n_overlap != 0) $display("FAIL abort_counts: abort %0d ok %0d done %0d ovl %0d expected 1 1 1 0", n_abort, n_ok, n_done, n_overlap);
    else pass_cnt++;
    total_cnt++;
    if (data_out !== 8'h01 || calc_crc !== 4'h7) $display("FAIL abort_data: got %h/%h expected 01/7", data_out, calc_crc);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    clear_counts();
    send_frame(8'h01, 4'h7, 0);
    send_frame(8'h5A, ref_crc(8'h5A), 0);
    total_cnt++;
    if (n_done != 2 || n_ok != 2 || n_abort != 0) $display("FAIL b2b_counts: done %0d ok %0d abort %0d expected 2 2 0", n_done, n_ok, n_abort);
    else pass_cnt++;
    total_cnt++;
    if (last_done_cyc - prev_done_cyc != 12) $display("FAIL b2b_spacing: got %0d expected 12", last_done_cyc - prev_done_cyc);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    send_frame(8'hC3, ref_crc(8'hC3), 0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, (i == 0));
    #2 rst = 1'b0;
    #1;
    total_cnt++;
    if ({data_out, rx_crc, calc_crc} !== 16'h0 || {frame_done, crc_ok, crc_err, frame_abort, busy} !== 5'b0) $display("FAIL midrst_outputs: got %h %b expected 0000 00000", {data_out, rx_crc, calc_crc}, {frame_done, crc_ok, crc_err, frame_abort, busy});
    else pass_cnt++;
    step(1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    clear_counts();
    send_frame(8'h01, 4'h7, 0);
    total_cnt++;
    if (n_ok != 1 || n_abort != 0 || data_out !== 8'h01) $display("FAIL midrst_recover: ok %0d abort %0d data %h expected 1 0 01", n_ok, n_abort, data_out);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [7:0] pay;
    logic [3:0] crc, good;
    int exp_abort;
    int pre;
    for (int f = 0; f < 40; f++) begin
      clear_counts();
      pay = 8'($urandom);
      good = ref_crc(pay);
      crc = ($urandom_range(1) == 1) ? good : (good ^ 4'($urandom_range(15, 1)));
      exp_abort = 0;
      if ($urandom_range(3) == 0) begin
        pre = int'($urandom_range(11, 1));
        for (int i = 0; i < pre; i++) step(1'($urandom_range(1)), 1'b1, (i == 0));
        exp_abort = 1;
      end
      send_frame(pay, crc, 30);
      total_cnt++;
      if (n_done != 1 || n_ok != int'(crc == good) || n_err != int'(crc != good) || n_abort != exp_abort)
        $display("FAIL rand_pulses[%0d]: done %0d ok %0d err %0d abort %0d expected 1 %0d %0d %0d", f, n_done, n_ok, n_err, n_abort, int'(crc == good), int'(crc != good), exp_abort);
      else pass_cnt++;
      total_cnt++;
      if (data_out !== pay || rx_crc !== crc || calc_crc !== good)
        $display("FAIL rand_data[%0d]: got %h/%h/%h expected %h/%h/%h", f, data_out, rx_crc, calc_crc, pay, crc, good);
      else pass_cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    last_done_cyc = 0;
    prev_done_cyc = 0;
    clear_counts();
    test_reset();
    test_good_frame();
    test_bad_crc();
    test_stall();
    test_abort();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
